traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The module SHALL have parameter DWELL_P1, default 8, meaning required clk cycles in phase P1 (M1 green, M2 green, MT red, S red).
REQ-002 The module SHALL have parameter DWELL_P2, default 3, meaning required cycles in P2 (M1 green, M2 yellow, MT red, S red).
REQ-003 The module SHALL have parameter DWELL_P3, default 6, meaning required cycles in P3 (M1 green, M2 red, MT green, S red).
REQ-004 The module SHALL have parameter DWELL_P4, default 3, meaning required cycles in P4 (M1 yellow, M2 red, MT yellow, S red).
REQ-005 The module SHALL have parameter DWELL_P5, default 4, meaning required cycles in P5 (M1, M2, MT red; S green).
REQ-006 The module SHALL have parameter DWELL_P6, default 3, meaning required cycles in P6 (M1, M2, MT red; S yellow).
REQ-007 The module SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 The module SHALL have ports light_M1, light_S, light_MT, light_M2, each input, 3 bits, observed lamp vectors (100 red, 010 yellow, 001 green).
REQ-010 The module SHALL have port fault_clr, input, 1 bit, a one-cycle pulse that clears the latched fault.
REQ-011 The module SHALL have port phase, output, 3 bits, decoded phase of the registered snapshot (0..5 = P1..P6, 7 = illegal).
REQ-012 The module SHALL have port locked, output, 1 bit, high while sequence and dwell checking is active.
REQ-013 The module SHALL have port fault, output, 1 bit, sticky fault flag.
REQ-014 The module SHALL have port fault_code, output, 3 bits, code of the first latched fault.
REQ-015 The module SHALL have port fault_count, output, 8 bits, saturating count of latched fault events since reset.

Function
REQ-016 Inputs SHALL be registered into a snapshot every cycle; all checks SHALL operate on the snapshot and its previous value, and fault SHALL assert on the second rising edge after an offending value is first presented.
REQ-017 ENCODING fault (code 1): any vector not exactly one of 100/010/001.
REQ-018 CONFLICT fault (code 2): all vectors well-encoded but the combination matches none of P1..P6.
REQ-019 SEQUENCE fault (code 3), checked only when locked: phase changes to anything other than its successor (P1->P2->P3->P4->P5->P6->P1).
REQ-020 A 5-bit dwell counter SHALL load 1 on each phase change and otherwise increment, saturating at 31.
REQ-021 DWELL_SHORT fault (code 4), when locked: legal phase change occurs with dwell counter below the DWELL value of the phase being left.
REQ-022 DWELL_LONG fault (code 5), when locked: phase unchanged while dwell counter already equals its DWELL value (flagged in cycle DWELL+1, not at the next change).
REQ-023 Simultaneous fault conditions SHALL record the lowest nonzero code.
REQ-024 State machine: SYNC (locked=0) -> LOCKED on the first legal successor phase change; LOCKED -> SYNC on any fault; the partial phase seen before lock SHALL NOT be dwell-checked.
REQ-025 ENCODING and CONFLICT SHALL be checked in both SYNC and LOCKED.
REQ-026 The first fault SHALL set fault=1 and fault_code; later faults SHALL NOT change fault_code while fault=1, but SHALL each increment fault_count (one per fault-entry cycle, saturating at 255).
REQ-027 fault_clr SHALL clear fault and fault_code to 0; a fault detected in the same cycle as fault_clr SHALL win (fault=1, new code).
REQ-028 A persisting illegal snapshot SHALL count once, on entry, not every cycle.

Reset
REQ-029 On rst: snapshot registers 0, phase=7, locked=0, fault=0, fault_code=0, fault_count=0, dwell counter=0, state SYNC.
REQ-030 No fault SHALL be raised in the first cycle after rst deasserts (snapshot holds reset value); rst mid-operation SHALL discard all history.

Structure
REQ-031 Package traffic_light_pkg SHALL hold lamp encodings (RED, YEL, GRN), phase enum P1..P6/ILLEGAL, fault code enum, and default dwell constants.
REQ-032 Combinational sub-module tl_phase_decode SHALL map the four vectors to phase and an encoding-error bit.

Verification
REQ-033 Drive nominal cycle (8,3,6,3,4,3 cycles) twice after reset -> locked=1 after first P1->P2 change, fault=0, fault_count=0.
REQ-034 Hold light_M1=011 one cycle -> fault=1, fault_code=1 two edges later, fault_count=1, locked=0.
REQ-035 Drive M1 green with S green (others red) -> fault_code=2.
REQ-036 While locked, jump P2->P5 -> fault_code=3; then fault_clr -> fault=0, fault_code=0, fault_count stays 1.
REQ-037 While locked, hold P3 7 cycles -> fault_code=5 in 7th cycle; separately leave P1 after 6 cycles -> fault_code=4.
REQ-038 Assert rst mid-P4 with fault=1 -> all outputs at reset values next cycle; resume mid-phase -> no dwell fault before lock.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, phase and fault enums, and default dwell lengths
// for the traffic light monitor.
package traffic_light_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    P1      = 3'd0,
    P2      = 3'd1,
    P3      = 3'd2,
    P4      = 3'd3,
    P5      = 3'd4,
    P6      = 3'd5,
    ILLEGAL = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    F_NONE        = 3'd0,
    F_ENCODING    = 3'd1,
    F_CONFLICT    = 3'd2,
    F_SEQUENCE    = 3'd3,
    F_DWELL_SHORT = 3'd4,
    F_DWELL_LONG  = 3'd5
  } fault_code_e;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } mon_state_e;

  localparam int unsigned DEF_DWELL_P1 = 8;
  localparam int unsigned DEF_DWELL_P2 = 3;
  localparam int unsigned DEF_DWELL_P3 = 6;
  localparam int unsigned DEF_DWELL_P4 = 3;
  localparam int unsigned DEF_DWELL_P5 = 4;
  localparam int unsigned DEF_DWELL_P6 = 3;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      P1:      return P2;
      P2:      return P3;
      P3:      return P4;
      P4:      return P5;
      P5:      return P6;
      P6:      return P1;
      default: return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Maps the four lamp vectors to a signal phase; any lamp that is not
// exactly one of red/yellow/green is reported as an encoding error.
module tl_phase_decode
  import traffic_light_pkg::*;
(
  input  logic [2:0] light_M1,
  input  logic [2:0] light_S,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_M2,
  output phase_e     phase,
  output logic       enc_err
);

  function automatic logic lamp_ok(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  always_comb begin
    enc_err = !(lamp_ok(light_M1) && lamp_ok(light_S) &&
                lamp_ok(light_MT) && lamp_ok(light_M2));
    phase = ILLEGAL;
    if (!enc_err) begin
      case ({light_M1, light_M2, light_MT, light_S})
        {GRN, GRN, RED, RED}: phase = P1;
        {GRN, YEL, RED, RED}: phase = P2;
        {GRN, RED, GRN, RED}: phase = P3;
        {YEL, RED, YEL, RED}: phase = P4;
        {RED, RED, RED, GRN}: phase = P5;
        {RED, RED, RED, YEL}: phase = P6;
        default:              phase = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the lamp outputs of a junction controller and latches encoding,
// conflict, sequence and dwell-time faults against a registered snapshot.
//
// state  | meaning
// SYNC   | waiting for a legal successor phase change; only encoding/conflict checked
// LOCKED | full sequence and dwell checking active
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned DWELL_P1 = DEF_DWELL_P1,
  parameter int unsigned DWELL_P2 = DEF_DWELL_P2,
  parameter int unsigned DWELL_P3 = DEF_DWELL_P3,
  parameter int unsigned DWELL_P4 = DEF_DWELL_P4,
  parameter int unsigned DWELL_P5 = DEF_DWELL_P5,
  parameter int unsigned DWELL_P6 = DEF_DWELL_P6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_S,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_M2,
  input  logic       fault_clr,
  output logic [2:0] phase,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  logic [2:0]  snap_m1, snap_s, snap_mt, snap_m2;
  logic        snap_vld;
  phase_e      phase_cur, phase_q;
  logic        enc_err;
  logic [4:0]  dwell_q, dwell_req;
  mon_state_e  state_q, state_d;
  fault_code_e det_code;
  logic        det, det_q, fault_evt, changed;

  tl_phase_decode u_decode (
    .light_M1 (snap_m1),
    .light_S  (snap_s),
    .light_MT (snap_mt),
    .light_M2 (snap_m2),
    .phase    (phase_cur),
    .enc_err  (enc_err)
  );

  assign phase     = phase_cur;
  assign locked    = (state_q == LOCKED);
  assign changed   = snap_vld && (phase_cur != phase_q);
  assign det       = (det_code != F_NONE);
  // Only the first cycle of a fault condition is an event; a held bad value counts once.
  assign fault_evt = det && !det_q;

  always_comb begin
    case (phase_q)
      P1:      dwell_req = 5'(DWELL_P1);
      P2:      dwell_req = 5'(DWELL_P2);
      P3:      dwell_req = 5'(DWELL_P3);
      P4:      dwell_req = 5'(DWELL_P4);
      P5:      dwell_req = 5'(DWELL_P5);
      P6:      dwell_req = 5'(DWELL_P6);
      default: dwell_req = 5'd31;
    endcase
  end

  // Priority order gives the lowest code when several conditions coincide.
  always_comb begin
    det_code = F_NONE;
    state_d  = state_q;
    if (snap_vld) begin
      if (enc_err)                                         det_code = F_ENCODING;
      else if (phase_cur == ILLEGAL)                       det_code = F_CONFLICT;
      else if (state_q == LOCKED) begin
        if (changed && (phase_cur != next_phase(phase_q))) det_code = F_SEQUENCE;
        else if (changed && (dwell_q < dwell_req))         det_code = F_DWELL_SHORT;
        else if (!changed && (dwell_q == dwell_req))       det_code = F_DWELL_LONG;
      end
      if (det_code != F_NONE)
        state_d = SYNC;
      else if ((state_q == SYNC) && changed && (phase_q != ILLEGAL) &&
               (phase_cur == next_phase(phase_q)))
        state_d = LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_m1     <= 3'd0;
      snap_s      <= 3'd0;
      snap_mt     <= 3'd0;
      snap_m2     <= 3'd0;
      snap_vld    <= 1'b0;
      phase_q     <= ILLEGAL;
      dwell_q     <= 5'd0;
      state_q     <= SYNC;
      det_q       <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_count <= 8'd0;
    end else begin
      snap_m1  <= light_M1;
      snap_s   <= light_S;
      snap_mt  <= light_MT;
      snap_m2  <= light_M2;
      snap_vld <= 1'b1;
      state_q  <= state_d;
      det_q    <= det;
      if (snap_vld) begin
        phase_q <= phase_cur;
        if (changed)               dwell_q <= 5'd1;
        else if (dwell_q != 5'd31) dwell_q <= dwell_q + 5'd1;
      end
      if (fault_evt) begin
        fault <= 1'b1;
        if (!fault || fault_clr) fault_code <= det_code;
        if (fault_count != 8'd255) fault_count <= fault_count + 8'd1;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: nominal cycling, each fault type,
// sticky code, clear priority and mid-run reset, with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light_M1, light_S, light_MT, light_M2;
  logic       fault_clr;
  logic [2:0] phase;
  logic       locked, fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  int tests = 0;
  int fails = 0;

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (light_M1),
    .light_S     (light_S),
    .light_MT    (light_MT),
    .light_M2    (light_M2),
    .fault_clr   (fault_clr),
    .phase       (phase),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // p = 1..6 selects P1..P6
  task automatic set_phase(input int p);
    case (p)
      1:       begin light_M1 = LG; light_M2 = LG; light_MT = LR; light_S = LR; end
      2:       begin light_M1 = LG; light_M2 = LY; light_MT = LR; light_S = LR; end
      3:       begin light_M1 = LG; light_M2 = LR; light_MT = LG; light_S = LR; end
      4:       begin light_M1 = LY; light_M2 = LR; light_MT = LY; light_S = LR; end
      5:       begin light_M1 = LR; light_M2 = LR; light_MT = LR; light_S = LG; end
      default: begin light_M1 = LR; light_M2 = LR; light_MT = LR; light_S = LY; end
    endcase
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input int p, input int n);
    set_phase(p);
    edges(n);
  endtask

  task automatic chk_status(input string tag, input logic f, input logic [2:0] code,
                            input logic [7:0] cnt, input logic lk);
    chk({tag, "_fault"}, 8'(fault), 8'(f));
    chk({tag, "_code"},  8'(fault_code), 8'(code));
    chk({tag, "_count"}, fault_count, cnt);
    chk({tag, "_locked"}, 8'(locked), 8'(lk));
  endtask

  initial begin
    rst = 1'b1;
    fault_clr = 1'b0;
    light_M1 = 3'd0; light_S = 3'd0; light_MT = 3'd0; light_M2 = 3'd0;
    edges(2);
    chk("reset_phase", 8'(phase), 8'd7);
    chk_status("reset", 1'b0, 3'd0, 8'd0, 1'b0);

    // Nominal sequence twice; lock on first P1->P2 change
    rst = 1'b0;
    chk("first_cycle_fault", 8'(fault), 8'd0);
    hold(1, 8);
    hold(2, 1);
    chk("p2_phase", 8'(phase), 8'd1);
    chk("prelock_locked", 8'(locked), 8'd0);
    hold(2, 1);
    chk("lock_after_p1p2", 8'(locked), 8'd1);
    hold(2, 1);
    hold(3, 6); hold(4, 3); hold(5, 4); hold(6, 3);
    hold(1, 8); hold(2, 3); hold(3, 6); hold(4, 3); hold(5, 4); hold(6, 3);
    chk_status("nominal", 1'b0, 3'd0, 8'd0, 1'b1);

    // Leave P1 after 6 cycles -> DWELL_SHORT, visible on the second edge
    hold(1, 6);
    hold(2, 1);
    chk("short_one_edge_fault", 8'(fault), 8'd0);
    hold(2, 1);
    chk_status("dwell_short", 1'b1, 3'd4, 8'd1, 1'b0);
    fault_clr = 1'b1;
    hold(2, 1);
    fault_clr = 1'b0;
    chk_status("clr1", 1'b0, 3'd0, 8'd1, 1'b0);

    // Relock at P2->P3, hold P3 7 cycles -> DWELL_LONG
    hold(3, 7);
    chk_status("p3_seven", 1'b0, 3'd0, 8'd1, 1'b1);
    hold(3, 1);
    chk_status("dwell_long", 1'b1, 3'd5, 8'd2, 1'b0);
    fault_clr = 1'b1;
    hold(3, 1);
    fault_clr = 1'b0;
    chk_status("clr2", 1'b0, 3'd0, 8'd2, 1'b0);

    // Relock at P3->P4, then jump P2->P5 -> SEQUENCE
    hold(4, 3); hold(5, 4); hold(6, 3); hold(1, 8); hold(2, 2);
    chk("locked_before_jump", 8'(locked), 8'd1);
    hold(5, 2);
    chk_status("sequence", 1'b1, 3'd3, 8'd3, 1'b0);
    fault_clr = 1'b1;
    hold(5, 1);
    fault_clr = 1'b0;
    chk_status("clr3", 1'b0, 3'd0, 8'd3, 1'b0);

    // Relock at P5->P6, then one cycle of M1=011 -> ENCODING
    hold(6, 2);
    chk("locked_p6", 8'(locked), 8'd1);
    light_M1 = 3'b011;
    edges(1);
    hold(6, 1);
    chk_status("encoding", 1'b1, 3'd1, 8'd4, 1'b0);
    fault_clr = 1'b1;
    hold(6, 1);
    fault_clr = 1'b0;
    chk("clr4_fault", 8'(fault), 8'd0);

    // M1 green with S green held 4 cycles -> CONFLICT, counted once
    light_M1 = LG; light_M2 = LR; light_MT = LR; light_S = LG;
    edges(4);
    chk_status("conflict", 1'b1, 3'd2, 8'd5, 1'b0);
    chk("conflict_phase", 8'(phase), 8'd7);
    hold(1, 2);
    chk("sticky_code", 8'(fault_code), 8'd2);

    // New fault in the same cycle as fault_clr wins
    light_M2 = 3'b000;
    edges(1);
    set_phase(1);
    fault_clr = 1'b1;
    edges(1);
    fault_clr = 1'b0;
    chk_status("clr_vs_fault", 1'b1, 3'd1, 8'd6, 1'b0);

    // Reset mid-P4 with fault set, then resume mid-phase
    hold(4, 2);
    rst = 1'b1;
    hold(4, 1);
    chk("midrst_phase", 8'(phase), 8'd7);
    chk_status("midrst", 1'b0, 3'd0, 8'd0, 1'b0);
    rst = 1'b0;
    hold(4, 1);
    chk("resume_phase", 8'(phase), 8'd3);
    chk("resume_fault", 8'(fault), 8'd0);
    hold(4, 1);
    hold(5, 4); hold(6, 3); hold(1, 8);
    chk_status("resume", 1'b0, 3'd0, 8'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
